systolic_array_os: RTL and testbench

SYSTOLIC_ARRAY_OS -- requirements
Module: systolic_array_os

---
 rtl/systolic_pkg.sv | 52 +++++
 rtl/systolic_array_os_if.sv | 38 +++
 rtl/systolic_pe.sv | 56 +++++
 rtl/systolic_array_os.sv | 207 ++++++++++++++++++++
 tb/tb_systolic_array_os.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared definitions for the output-stationary systolic array.
//   state_t     - job controller states (IDLE, FEED, FLUSH, DRAIN)
//   DEF_*       - default parameter values for the array and its interface
//   acc_add()   - accumulator update: saturating or wrap-around signed add
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int DEF_HEIGHT = 4;
    localparam int DEF_WIDTH  = 4;
    localparam int DEF_IWIDTH = 8;
    localparam int DEF_OWIDTH = 24;
    localparam int DEF_SAT    = 1;

    // Width the add is evaluated in; wide enough that acc + product never
    // overflows before the clamp/wrap step for any legal OWIDTH (<= 62).
    localparam int ACC_CALC_W = 64;

    // Adds a sign-extended product to a sign-extended accumulator and brings
    // the sum back into the signed ow-bit range, either by clamping (sat=1)
    // or by keeping the low ow bits and re-extending (sat=0).
    function automatic logic signed [ACC_CALC_W-1:0] acc_add(
        input logic signed [ACC_CALC_W-1:0] acc,
        input logic signed [ACC_CALC_W-1:0] prod,
        input int                           ow,
        input bit                           sat
    );
        logic signed [ACC_CALC_W-1:0] sum;
        logic signed [ACC_CALC_W-1:0] hi;
        logic signed [ACC_CALC_W-1:0] lo;
        sum = acc + prod;
        hi  = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (ow - 1));
        if (sat) begin
            if (sum > hi) begin
                acc_add = hi;
            end else if (sum < lo) begin
                acc_add = lo;
            end else begin
                acc_add = sum;
            end
        end else begin
            acc_add = (sum <<< (ACC_CALC_W - ow)) >>> (ACC_CALC_W - ow);
        end
    endfunction

endpackage

// File: rtl/systolic_array_os_if.sv
// systolic_array_os_if: job, operand-stream and result-stream signals of the
// systolic array.
//   master: start, k_len, in_valid, ifm, wght, out_ready driven; rest observed
//   slave : the array side (drives in_ready, out_valid, ofm, out_row, busy, done)
interface systolic_array_os_if
    import systolic_pkg::*;
#(
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int IWIDTH = DEF_IWIDTH,
    parameter int OWIDTH = DEF_OWIDTH
);
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic                     start;
    logic [15:0]              k_len;
    logic                     in_valid;
    logic                     in_ready;
    logic [HEIGHT*IWIDTH-1:0] ifm;
    logic [WIDTH*IWIDTH-1:0]  wght;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH*OWIDTH-1:0]  ofm;
    logic [RW-1:0]            out_row;
    logic                     busy;
    logic                     done;

    modport master (
        output start, k_len, in_valid, ifm, wght, out_ready,
        input  in_ready, out_valid, ofm, out_row, busy, done
    );

    modport slave (
        input  start, k_len, in_valid, ifm, wght, out_ready,
        output in_ready, out_valid, ofm, out_row, busy, done
    );

endinterface

// File: rtl/systolic_pe.sv
// systolic_pe: one output-stationary processing element.
//   clk, clr         - clock; synchronous clear of all state (reset or job start)
//   a_in/a_vld_in    - operand from the left, forwarded right as a_out/a_vld_out
//   b_in/b_vld_in    - weight from above, forwarded down as b_out/b_vld_out
//   acc              - local accumulator (signed OWIDTH)
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int IWIDTH = DEF_IWIDTH,
    parameter int OWIDTH = DEF_OWIDTH,
    parameter int SAT    = DEF_SAT
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [IWIDTH-1:0] a_in,
    input  logic              a_vld_in,
    input  logic [IWIDTH-1:0] b_in,
    input  logic              b_vld_in,
    output logic [IWIDTH-1:0] a_out,
    output logic              a_vld_out,
    output logic [IWIDTH-1:0] b_out,
    output logic              b_vld_out,
    output logic [OWIDTH-1:0] acc
);
    logic signed [OWIDTH-1:0]     acc_r;
    logic signed [2*IWIDTH-1:0]   prod_s;
    logic signed [ACC_CALC_W-1:0] sum_s;

    // Full-precision product and the clamped/wrapped running sum.
    always_comb begin
        prod_s = (2*IWIDTH)'($signed(a_in)) * (2*IWIDTH)'($signed(b_in));
        sum_s  = acc_add(ACC_CALC_W'(acc_r), ACC_CALC_W'(prod_s), OWIDTH, SAT != 0);
    end

    // Forward registers and accumulator; a bubble on either side skips the MAC.
    always_ff @(posedge clk) begin
        if (clr) begin
            a_out     <= '0;
            a_vld_out <= 1'b0;
            b_out     <= '0;
            b_vld_out <= 1'b0;
            acc_r     <= '0;
        end else begin
            a_out     <= a_in;
            a_vld_out <= a_vld_in;
            b_out     <= b_in;
            b_vld_out <= b_vld_in;
            if (a_vld_in && b_vld_in) begin
                acc_r <= sum_s[OWIDTH-1:0];
            end
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/systolic_array_os.sv
// systolic_array_os: HEIGHT x WIDTH output-stationary systolic matrix multiplier.
//   clk, rst - clock and synchronous active-high reset
//   bus      - systolic_array_os_if.slave: job start/k_len, operand stream
//              (in_valid/in_ready, ifm, wght), result stream (out_valid/
//              out_ready, ofm, out_row), busy and one-cycle done
// A job takes k_len operand beats, flushes the skewed pipeline, then presents
// the accumulator rows 0..HEIGHT-1 one per handshake.
module systolic_array_os
    import systolic_pkg::*;
#(
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int IWIDTH = DEF_IWIDTH,
    parameter int OWIDTH = DEF_OWIDTH,
    parameter int SAT    = DEF_SAT
) (
    input logic               clk,
    input logic               rst,
    systolic_array_os_if.slave bus
);
    localparam int              RW         = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [15:0]     FLUSH_LAST = 16'(HEIGHT + WIDTH - 2);
    localparam logic [RW-1:0]   LAST_ROW   = RW'(HEIGHT - 1);

    if (OWIDTH < 2*IWIDTH || OWIDTH > ACC_CALC_W - 2) begin : g_bad_owidth
        $error("systolic_array_os: OWIDTH must be >= 2*IWIDTH and <= 62");
    end

    state_t        state_r, state_s;
    logic [15:0]   k_len_r, beat_r, flush_r;
    logic [RW-1:0] row_r;
    logic          done_r;
    logic          start_s, accept_s, out_hs_s, last_beat_s, clr_s;
    logic [WIDTH*OWIDTH-1:0] ofm_s;

    logic [IWIDTH-1:0] a_d [HEIGHT][WIDTH+1];
    logic              a_v [HEIGHT][WIDTH+1];
    logic [IWIDTH-1:0] b_d [HEIGHT+1][WIDTH];
    logic              b_v [HEIGHT+1][WIDTH];
    logic [OWIDTH-1:0] acc_w [HEIGHT][WIDTH];

    assign start_s     = (state_r == ST_IDLE) && bus.start;
    assign accept_s    = (state_r == ST_FEED) && bus.in_valid;
    assign out_hs_s    = (state_r == ST_DRAIN) && bus.out_ready;
    assign last_beat_s = (beat_r == k_len_r - 16'd1);
    // A new job wipes accumulators and every in-flight valid bit.
    assign clr_s       = rst || start_s;

    // Next-state logic of the job controller.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = (bus.k_len == 16'd0) ? ST_DRAIN : ST_FEED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FEED: begin
                if (accept_s && last_beat_s) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_FEED;
                end
            end
            ST_FLUSH: begin
                if (flush_r == FLUSH_LAST) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                if (out_hs_s && (row_r == LAST_ROW)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Job bookkeeping: latched length, beat/flush counters, drain row, done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_len_r <= 16'd0;
            beat_r  <= 16'd0;
            flush_r <= 16'd0;
            row_r   <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= out_hs_s && (row_r == LAST_ROW);
            if (start_s) begin
                k_len_r <= bus.k_len;
                beat_r  <= 16'd0;
                flush_r <= 16'd0;
                row_r   <= '0;
            end else begin
                if (accept_s) begin
                    beat_r <= beat_r + 16'd1;
                end
                if (state_r == ST_FLUSH) begin
                    flush_r <= flush_r + 16'd1;
                end
                if (out_hs_s) begin
                    row_r <= (row_r == LAST_ROW) ? '0 : row_r + RW'(1);
                end
            end
        end
    end

    // Row h enters h cycles late so it meets column w's weights on the diagonal.
    for (genvar h = 0; h < HEIGHT; h++) begin : g_row_skew
        logic [IWIDTH-1:0] sr_d [0:h];
        logic              sr_v [0:h];
        // Row operand capture and delay line.
        always_ff @(posedge clk) begin
            if (clr_s) begin
                for (int d = 0; d <= h; d++) begin
                    sr_d[d] <= '0;
                    sr_v[d] <= 1'b0;
                end
            end else begin
                sr_d[0] <= bus.ifm[h*IWIDTH +: IWIDTH];
                sr_v[0] <= accept_s;
                for (int d = 1; d <= h; d++) begin
                    sr_d[d] <= sr_d[d-1];
                    sr_v[d] <= sr_v[d-1];
                end
            end
        end
        assign a_d[h][0] = sr_d[h];
        assign a_v[h][0] = sr_v[h];
    end

    for (genvar w = 0; w < WIDTH; w++) begin : g_col_skew
        logic [IWIDTH-1:0] sr_d [0:w];
        logic              sr_v [0:w];
        // Column weight capture and delay line.
        always_ff @(posedge clk) begin
            if (clr_s) begin
                for (int d = 0; d <= w; d++) begin
                    sr_d[d] <= '0;
                    sr_v[d] <= 1'b0;
                end
            end else begin
                sr_d[0] <= bus.wght[w*IWIDTH +: IWIDTH];
                sr_v[0] <= accept_s;
                for (int d = 1; d <= w; d++) begin
                    sr_d[d] <= sr_d[d-1];
                    sr_v[d] <= sr_v[d-1];
                end
            end
        end
        assign b_d[0][w] = sr_d[w];
        assign b_v[0][w] = sr_v[w];
    end

    for (genvar h = 0; h < HEIGHT; h++) begin : g_pe_row
        for (genvar w = 0; w < WIDTH; w++) begin : g_pe_col
            systolic_pe #(.IWIDTH(IWIDTH), .OWIDTH(OWIDTH), .SAT(SAT)) u_pe (
                .clk      (clk),
                .clr      (clr_s),
                .a_in     (a_d[h][w]),
                .a_vld_in (a_v[h][w]),
                .b_in     (b_d[h][w]),
                .b_vld_in (b_v[h][w]),
                .a_out    (a_d[h][w+1]),
                .a_vld_out(a_v[h][w+1]),
                .b_out    (b_d[h+1][w]),
                .b_vld_out(b_v[h+1][w]),
                .acc      (acc_w[h][w])
            );
        end
    end

    // Drain mux: the selected accumulator row, forced to zero outside DRAIN.
    always_comb begin
        ofm_s = '0;
        if (state_r == ST_DRAIN) begin
            for (int w = 0; w < WIDTH; w++) begin
                ofm_s[w*OWIDTH +: OWIDTH] = acc_w[row_r][w];
            end
        end else begin
            ofm_s = '0;
        end
    end

    assign bus.in_ready  = (state_r == ST_FEED);
    assign bus.out_valid = (state_r == ST_DRAIN);
    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.done      = done_r;
    assign bus.out_row   = (state_r == ST_DRAIN) ? row_r : '0;
    assign bus.ofm       = ofm_s;

endmodule

// File: tb/tb_systolic_array_os.sv
// Directed bench: a default 4x4 array plus two 2x2 / OWIDTH=16 arrays
// (saturating and wrapping) that share one stimulus stream.
module tb_systolic_array_os;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_array_os_if #(.HEIGHT(4), .WIDTH(4), .IWIDTH(8), .OWIDTH(24)) ifa ();
    systolic_array_os_if #(.HEIGHT(2), .WIDTH(2), .IWIDTH(8), .OWIDTH(16)) ifb ();
    systolic_array_os_if #(.HEIGHT(2), .WIDTH(2), .IWIDTH(8), .OWIDTH(16)) ifc ();

    systolic_array_os #(.HEIGHT(4), .WIDTH(4), .IWIDTH(8), .OWIDTH(24), .SAT(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    systolic_array_os #(.HEIGHT(2), .WIDTH(2), .IWIDTH(8), .OWIDTH(16), .SAT(1)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));
    systolic_array_os #(.HEIGHT(2), .WIDTH(2), .IWIDTH(8), .OWIDTH(16), .SAT(0)) dut_c (
        .clk(clk), .rst(rst), .bus(ifc.slave));

    assign ifc.start     = ifb.start;
    assign ifc.k_len     = ifb.k_len;
    assign ifc.in_valid  = ifb.in_valid;
    assign ifc.ifm       = ifb.ifm;
    assign ifc.wght      = ifb.wght;
    assign ifc.out_ready = ifb.out_ready;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_a [4][4];
    int exp_b [2][2];
    int exp_c [2][2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    function automatic int opa(int p, int k, int h);
        return ((k*37 + h*11 + p*13 + 5) % 256) - 128;
    endfunction

    function automatic int opw(int p, int k, int w);
        return ((k*53 + w*29 + p*7 + 17) % 256) - 128;
    endfunction

    task automatic ref_a(input int p, input int kl);
        for (int h = 0; h < 4; h++)
            for (int w = 0; w < 4; w++) begin
                exp_a[h][w] = 0;
                for (int k = 0; k < kl; k++) exp_a[h][w] += opa(p, k, h) * opw(p, k, w);
            end
    endtask

    task automatic start_a(input int kl);
        ifa.start = 1'b1;
        ifa.k_len = 16'(kl);
        tick();
        ifa.start = 1'b0;
    endtask

    task automatic feed_a(input int p, input int nbeats, input bit gaps);
        for (int k = 0; k < nbeats; k++) begin
            if (gaps) begin
                ifa.in_valid = 1'b0;
                tick();
            end
            ifa.in_valid = 1'b1;
            for (int h = 0; h < 4; h++) ifa.ifm[h*8 +: 8] = 8'(opa(p, k, h));
            for (int w = 0; w < 4; w++) ifa.wght[w*8 +: 8] = 8'(opw(p, k, w));
            chk("a_in_ready", 64'(ifa.in_ready), 64'd1);
            tick();
        end
        ifa.in_valid = 1'b0;
    endtask

    task automatic wait_valid_a();
        for (int i = 0; i < 40 && !ifa.out_valid; i++) tick();
        chk("a_wait_out_valid", 64'(ifa.out_valid), 64'd1);
    endtask

    task automatic check_row_a(input int h);
        chk("a_out_valid", 64'(ifa.out_valid), 64'd1);
        chk("a_out_row", 64'(ifa.out_row), 64'(h));
        for (int w = 0; w < 4; w++)
            chk($sformatf("a_ofm_r%0d_c%0d", h, w), 64'($signed(ifa.ofm[w*24 +: 24])), 64'(exp_a[h][w]));
    endtask

    task automatic drain_a(input int stall_row);
        for (int h = 0; h < 4; h++) begin
            check_row_a(h);
            if (h == stall_row) begin
                ifa.out_ready = 1'b0;
                repeat (5) begin
                    tick();
                    check_row_a(h);
                end
                ifa.out_ready = 1'b1;
            end
            tick();
        end
        chk("a_done", 64'(ifa.done), 64'd1);
        chk("a_out_valid_after", 64'(ifa.out_valid), 64'd0);
        chk("a_busy_after", 64'(ifa.busy), 64'd0);
        tick();
        chk("a_done_one_cycle", 64'(ifa.done), 64'd0);
        chk("a_busy_idle", 64'(ifa.busy), 64'd0);
    endtask

    task automatic check_outputs_zero_a(input string tag);
        chk({tag, "_in_ready"}, 64'(ifa.in_ready), 64'd0);
        chk({tag, "_out_valid"}, 64'(ifa.out_valid), 64'd0);
        chk({tag, "_done"}, 64'(ifa.done), 64'd0);
        chk({tag, "_busy"}, 64'(ifa.busy), 64'd0);
        chk({tag, "_out_row"}, 64'(ifa.out_row), 64'd0);
        chk({tag, "_ofm"}, 64'(ifa.ofm == '0), 64'd1);
    endtask

    task automatic start_bc(input int kl);
        ifb.start = 1'b1;
        ifb.k_len = 16'(kl);
        tick();
        ifb.start = 1'b0;
    endtask

    task automatic feed_bc(input int a0, input int a1, input int w0, input int w1, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            ifb.in_valid = 1'b1;
            ifb.ifm  = {8'(a1), 8'(a0)};
            ifb.wght = {8'(w1), 8'(w0)};
            chk("bc_in_ready", 64'(ifb.in_ready && ifc.in_ready), 64'd1);
            tick();
        end
        ifb.in_valid = 1'b0;
    endtask

    task automatic drain_bc();
        for (int i = 0; i < 20 && !ifb.out_valid; i++) tick();
        for (int h = 0; h < 2; h++) begin
            chk("b_out_valid", 64'(ifb.out_valid), 64'd1);
            chk("c_out_valid", 64'(ifc.out_valid), 64'd1);
            chk("b_out_row", 64'(ifb.out_row), 64'(h));
            chk("c_out_row", 64'(ifc.out_row), 64'(h));
            for (int w = 0; w < 2; w++) begin
                chk($sformatf("b_ofm_r%0d_c%0d", h, w), 64'($signed(ifb.ofm[w*16 +: 16])), 64'(exp_b[h][w]));
                chk($sformatf("c_ofm_r%0d_c%0d", h, w), 64'($signed(ifc.ofm[w*16 +: 16])), 64'(exp_c[h][w]));
            end
            tick();
        end
        chk("bc_done", 64'({ifb.done, ifc.done}), 64'd3);
        chk("bc_out_valid_after", 64'({ifb.out_valid, ifc.out_valid}), 64'd0);
        tick();
        chk("bc_done_one_cycle", 64'({ifb.done, ifc.done}), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        ifa.start = 1'b0; ifa.k_len = 16'd0; ifa.in_valid = 1'b0;
        ifa.ifm = '0; ifa.wght = '0; ifa.out_ready = 1'b1;
        ifb.start = 1'b0; ifb.k_len = 16'd0; ifb.in_valid = 1'b0;
        ifb.ifm = '0; ifb.wght = '0; ifb.out_ready = 1'b1;
        repeat (3) tick();
        check_outputs_zero_a("reset");
        chk("reset_bc_busy", 64'({ifb.busy, ifc.busy}), 64'd0);
        rst = 1'b0;
        tick();

        // 2x2, one beat: rows {12,15}, {-8,-10}; out_valid at accept+4.
        exp_b = '{'{12, 15}, '{-8, -10}};
        exp_c = exp_b;
        start_bc(1);
        feed_bc(3, -2, 4, 5, 1);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("bc_out_valid_early_%0d", i), 64'(ifb.out_valid), 64'd0);
            tick();
        end
        chk("bc_out_valid_at_accept_plus_4", 64'({ifb.out_valid, ifc.out_valid}), 64'd3);
        drain_bc();

        // Four beats of -128*-128: saturates to 32767, wraps to 65536 mod 2^16 = 0.
        exp_b = '{'{32767, 32767}, '{32767, 32767}};
        exp_c = '{'{0, 0}, '{0, 0}};
        start_bc(4);
        feed_bc(-128, -128, -128, -128, 4);
        drain_bc();

        // 4x4, k_len=8 with a bubble before every beat.
        ref_a(1, 8);
        start_a(8);
        feed_a(1, 8, 1'b1);
        wait_valid_a();
        drain_a(-1);

        // Back-pressure: row 1 held for 5 cycles.
        ref_a(2, 3);
        start_a(3);
        feed_a(2, 3, 1'b0);
        wait_valid_a();
        drain_a(1);

        // Reset after 3 of 8 beats, then a fresh 2-beat job.
        start_a(8);
        feed_a(3, 3, 1'b0);
        rst = 1'b1;
        tick();
        check_outputs_zero_a("midreset");
        rst = 1'b0;
        tick();
        chk("midreset_no_done", 64'(ifa.done), 64'd0);
        ref_a(4, 2);
        start_a(2);
        feed_a(4, 2, 1'b0);
        wait_valid_a();
        drain_a(-1);

        // k_len=0: straight to DRAIN with zero rows; a start inside DRAIN is ignored.
        ref_a(0, 0);
        ifa.out_ready = 1'b0;
        start_a(0);
        chk("k0_busy", 64'(ifa.busy), 64'd1);
        chk("k0_in_ready", 64'(ifa.in_ready), 64'd0);
        ifa.start = 1'b1;
        ifa.k_len = 16'd5;
        tick();
        ifa.start = 1'b0;
        chk("k0_still_drain", 64'(ifa.out_valid), 64'd1);
        chk("k0_row_held", 64'(ifa.out_row), 64'd0);
        ifa.out_ready = 1'b1;
        drain_a(-1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
